// File: rtl/sram_responder_model.sv
// Cycle-based stand-in for a 128Kx16 asynchronous SRAM: samples the controller's pins on clk,
// enforces access and write-pulse widths in cycles, and flags timing violations.
//
// state      | meaning
// IDLE       | bus idle or deselected, dq released
// RD_ACCESS  | read requested, counting stable-address cycles up to ACC_CYC
// RD_DRIVE   | access time met, driving mem[addr_q] onto dq
// WR_PULSE   | WE# low, tracking pulse width, write data and address stability
module sram_responder_model #(
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = 16,
   parameter int CLK_MHZ = 50,
   parameter int T_AA_NS = 55,
   parameter int T_WP_NS = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_dq,
   input  logic              sram_ce_n,
   input  logic              sram_oe_n,
   input  logic              sram_we_n,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
   output logic              viol_wp,
   output logic              viol_addr
);

   localparam int ACC_CYC = (T_AA_NS * CLK_MHZ + 999) / 1000;
   localparam int WP_CYC  = (T_WP_NS * CLK_MHZ + 999) / 1000;
   localparam int DEPTH   = 2 ** ADDR_W;
   localparam logic [7:0] ACC_C8 = 8'(ACC_CYC);
   localparam logic [7:0] WP_C8  = 8'(WP_CYC);

   // cnt saturates at 255, so larger targets could never be reached
   if (ACC_CYC < 1 || WP_CYC < 1 || ACC_CYC > 255 || WP_CYC > 255) begin : g_param_check
      $fatal(1, "sram_responder_model: ACC_CYC/WP_CYC must lie in 1..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_ACCESS,
      ST_RD_DRIVE,
      ST_WR_PULSE
   } state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [ADDR_W-1:0]   r_addr_q;
   logic [DATA_W-1:0]   r_dq_q;
   logic                r_ce_q;
   logic                r_oe_q;
   logic                r_we_q;
   logic [7:0]          r_cnt;
   logic [7:0]          w_cnt_nx;
   logic [7:0]          w_cnt_inc;
   logic [ADDR_W-1:0]   r_acc_addr;
   logic [ADDR_W-1:0]   w_acc_addr_nx;
   logic [ADDR_W-1:0]   r_wa;
   logic [ADDR_W-1:0]   w_wa_nx;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   w_wdata_nx;
   logic                r_poison;
   logic                w_poison_nx;
   logic [DATA_W-1:0]   r_rd_data;
   logic [DATA_W-1:0]   r_dbg_data;
   logic [15:0]         r_rd_count;
   logic [15:0]         r_wr_count;
   logic                r_viol_wp;
   logic                r_viol_addr;
   logic                w_wr_cond;
   logic                w_rd_cond;
   logic                w_addr_chg;
   logic                w_wa_chg;
   logic                w_commit;
   logic                w_rd_done;
   logic                w_set_wp;
   logic                w_set_addr;
   logic                w_dq_oe;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   assign w_wr_cond  = !r_ce_q && !r_we_q;
   assign w_rd_cond  = !r_ce_q && !r_oe_q && r_we_q;
   assign w_addr_chg = (r_addr_q != r_acc_addr);
   assign w_wa_chg   = (r_addr_q != r_wa);
   assign w_cnt_inc  = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

   // Release is combinational so dq never shows stale data for a new address
   assign w_dq_oe = (r_state == ST_RD_DRIVE) && !w_addr_chg;
   assign sram_dq = w_dq_oe ? r_rd_data : {DATA_W{1'bz}};

   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_acc_addr_nx = r_acc_addr;
      w_wa_nx       = r_wa;
      w_wdata_nx    = r_wdata;
      w_poison_nx   = r_poison;
      w_commit      = 1'b0;
      w_rd_done     = 1'b0;
      w_set_wp      = 1'b0;
      w_set_addr    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nx = 8'd0;
            if (w_wr_cond) begin
               w_state_nx  = ST_WR_PULSE;
               w_cnt_nx    = 8'd1;
               w_wa_nx     = r_addr_q;
               w_wdata_nx  = r_dq_q;
               w_poison_nx = 1'b0;
            end else if (w_rd_cond) begin
               w_state_nx    = ST_RD_ACCESS;
               w_acc_addr_nx = r_addr_q;
            end
         end
         ST_RD_ACCESS: begin
            if (w_wr_cond) begin
               w_state_nx  = ST_WR_PULSE;
               w_cnt_nx    = 8'd1;
               w_wa_nx     = r_addr_q;
               w_wdata_nx  = r_dq_q;
               w_poison_nx = 1'b0;
            end else if (!w_rd_cond) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = 8'd0;
            end else if (w_addr_chg) begin
               w_cnt_nx      = 8'd0;
               w_acc_addr_nx = r_addr_q;
            end else if (w_cnt_inc >= ACC_C8) begin
               w_state_nx = ST_RD_DRIVE;
               w_cnt_nx   = w_cnt_inc;
               w_rd_done  = 1'b1;
            end else begin
               w_cnt_nx = w_cnt_inc;
            end
         end
         ST_RD_DRIVE: begin
            if (!w_rd_cond) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = 8'd0;
            end else if (w_addr_chg) begin
               w_state_nx    = ST_RD_ACCESS;
               w_cnt_nx      = 8'd0;
               w_acc_addr_nx = r_addr_q;
            end
         end
         ST_WR_PULSE: begin
            if (w_wr_cond) begin
               w_cnt_nx   = w_cnt_inc;
               w_wdata_nx = r_dq_q;
               if (w_wa_chg) begin
                  w_poison_nx = 1'b1;
                  w_set_addr  = 1'b1;
               end
            end else begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = 8'd0;
               if (r_cnt < WP_C8) begin
                  w_set_wp = 1'b1;
               end else if (!r_poison) begin
                  w_commit = 1'b1;
               end
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr_q    <= '0;
         r_dq_q      <= '0;
         r_ce_q      <= 1'b1;
         r_oe_q      <= 1'b1;
         r_we_q      <= 1'b1;
         r_cnt       <= 8'd0;
         r_acc_addr  <= '0;
         r_wa        <= '0;
         r_wdata     <= '0;
         r_poison    <= 1'b0;
         r_dbg_data  <= '0;
         r_rd_count  <= 16'd0;
         r_wr_count  <= 16'd0;
         r_viol_wp   <= 1'b0;
         r_viol_addr <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_addr_q    <= sram_addr;
         r_dq_q      <= sram_dq;
         r_ce_q      <= sram_ce_n;
         r_oe_q      <= sram_oe_n;
         r_we_q      <= sram_we_n;
         r_cnt       <= w_cnt_nx;
         r_acc_addr  <= w_acc_addr_nx;
         r_wa        <= w_wa_nx;
         r_wdata     <= w_wdata_nx;
         r_poison    <= w_poison_nx;
         r_dbg_data  <= r_mem[dbg_addr];
         r_rd_count  <= r_rd_count + {15'd0, w_rd_done};
         r_wr_count  <= r_wr_count + {15'd0, w_commit};
         r_viol_wp   <= r_viol_wp | w_set_wp;
         r_viol_addr <= r_viol_addr | w_set_addr;
      end
   end

   // Array has no reset: contents survive rst exactly like the real part
   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[r_wa] <= r_wdata;
      end
      r_rd_data <= r_mem[r_addr_q];
   end

   assign dbg_data  = r_dbg_data;
   assign rd_count  = r_rd_count;
   assign wr_count  = r_wr_count;
   assign viol_wp   = r_viol_wp;
   assign viol_addr = r_viol_addr;

endmodule

// File: tb/tb_sram_responder_model.sv
// Directed bench for sram_responder_model: pin-level controller stimulus, read responses
// checked by a scoreboard monitor, status/backdoor values checked inline.
module tb_sram_responder_model;

   localparam int ACC_CYC = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] sram_addr = '0;
   logic [16:0] dbg_addr = '0;
   wire  [15:0] sram_dq;
   logic        ce_n = 1'b1;
   logic        oe_n = 1'b1;
   logic        we_n = 1'b1;
   logic        tb_dq_en = 1'b0;
   logic [15:0] tb_dq = '0;
   logic [15:0] dbg_data;
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic        viol_wp;
   logic        viol_addr;
   logic [16:0] tb_addr_q = '0;

   typedef struct {
      logic [15:0] data;
      logic [16:0] addr;
      bit          chk_z;
      int          zrun;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass = 0;
   int   n_total = 0;

   assign sram_dq = tb_dq_en ? tb_dq : 16'hzzzz;

   always #5 clk = ~clk;

   always @(posedge clk) tb_addr_q <= sram_addr;

   sram_responder_model dut (
      .clk       (clk),
      .rst       (rst),
      .sram_addr (sram_addr),
      .sram_dq   (sram_dq),
      .sram_ce_n (ce_n),
      .sram_oe_n (oe_n),
      .sram_we_n (we_n),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .viol_wp   (viol_wp),
      .viol_addr (viol_addr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_read(input logic [16:0] a, input logic [15:0] d, input bit cz, input int zr);
      exp_t e;
      e.data  = d;
      e.addr  = a;
      e.chk_z = cz;
      e.zrun  = zr;
      sb_q.push_back(e);
   endtask

   task automatic sram_write(input logic [16:0] a, input logic [15:0] d, input int lows);
      sram_addr = a;
      tb_dq     = d;
      tb_dq_en  = 1'b1;
      ce_n      = 1'b0;
      we_n      = 1'b0;
      cyc(lows);
      we_n      = 1'b1;
      ce_n      = 1'b1;
      tb_dq_en  = 1'b0;
      cyc(3);
   endtask

   task automatic sram_read(input logic [16:0] a, input logic [15:0] d);
      expect_read(a, d, 1'b0, 0);
      sram_addr = a;
      ce_n      = 1'b0;
      oe_n      = 1'b0;
      cyc(7);
      ce_n      = 1'b1;
      oe_n      = 1'b1;
      cyc(3);
   endtask

   task automatic check_dbg(input logic [16:0] a, input logic [15:0] d, input string name);
      dbg_addr = a;
      cyc(2);
      check(name, dbg_data, d);
   endtask

   // Monitor: every z->driven transition on dq consumes one expected read
   initial begin
      bit   drv_prev = 1'b0;
      bit   have_cur = 1'b0;
      int   zrun = 0;
      exp_t cur;
      forever begin
         @(negedge clk);
         if (rst || tb_dq_en) begin
            drv_prev = 1'b0;
            zrun     = 0;
         end else if (sram_dq !== 16'hzzzz) begin
            if (!drv_prev) begin
               check("read_pending_at_drive", (sb_q.size() > 0), 1);
               if (sb_q.size() > 0) begin
                  cur      = sb_q.pop_front();
                  have_cur = 1'b1;
                  if (cur.chk_z) check("z_cycles_before_drive", zrun, cur.zrun);
               end
            end
            if (have_cur) begin
               check("read_data", sram_dq, cur.data);
               check("drive_addr_matches", tb_addr_q, cur.addr);
            end
            drv_prev = 1'b1;
            zrun     = 0;
         end else begin
            drv_prev = 1'b0;
            zrun++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(2);
      check("rst_rd_count", rd_count, 0);
      check("rst_wr_count", wr_count, 0);
      check("rst_viol_wp", viol_wp, 0);
      check("rst_viol_addr", viol_addr, 0);
      check("rst_dbg_data", dbg_data, 0);
      check("rst_dq_z", (sram_dq === 16'hzzzz), 1);
      rst = 1'b0;
      cyc(2);

      // basic write then read back
      sram_write(17'h00010, 16'h1234, 3);
      sram_read(17'h00010, 16'h1234);
      check("t1_wr_count", wr_count, 1);
      check("t1_rd_count", rd_count, 1);
      check_dbg(17'h00010, 16'h1234, "t1_dbg_data");

      // known contents for later checks; 0x20 uses the minimum legal pulse of 2 cycles
      sram_write(17'h00011, 16'h4321, 3);
      sram_write(17'h00020, 16'h2222, 2);
      sram_write(17'h00030, 16'h3333, 3);
      sram_write(17'h00031, 16'h3131, 3);
      sram_write(17'h00050, 16'h1111, 3);
      check("prewrite_wr_count", wr_count, 6);
      check("min_pulse_no_viol_wp", viol_wp, 0);
      check_dbg(17'h00020, 16'h2222, "min_pulse_committed");

      // short WE# pulse
      sram_write(17'h00020, 16'hBEEF, 1);
      check("short_pulse_viol_wp", viol_wp, 1);
      check("short_pulse_wr_count", wr_count, 6);
      check_dbg(17'h00020, 16'h2222, "short_pulse_mem_kept");

      // address moves during the pulse
      sram_addr = 17'h00030;
      tb_dq     = 16'hDEAD;
      tb_dq_en  = 1'b1;
      ce_n      = 1'b0;
      we_n      = 1'b0;
      cyc(2);
      sram_addr = 17'h00031;
      cyc(2);
      we_n      = 1'b1;
      ce_n      = 1'b1;
      tb_dq_en  = 1'b0;
      cyc(3);
      check("addr_move_viol_addr", viol_addr, 1);
      check("addr_move_wr_count", wr_count, 6);
      check_dbg(17'h00030, 16'h3333, "addr_move_mem30_kept");
      check_dbg(17'h00031, 16'h3131, "addr_move_mem31_kept");

      // OE# held while the address steps: one release cycle then ACC_CYC access cycles
      expect_read(17'h00010, 16'h1234, 1'b0, 0);
      expect_read(17'h00011, 16'h4321, 1'b1, ACC_CYC + 1);
      sram_addr = 17'h00010;
      ce_n      = 1'b0;
      oe_n      = 1'b0;
      cyc(7);
      sram_addr = 17'h00011;
      cyc(8);
      ce_n      = 1'b1;
      oe_n      = 1'b1;
      cyc(3);
      check("step_rd_count", rd_count, 3);

      // WE# dominates OE#
      sram_addr = 17'h00040;
      tb_dq     = 16'h5A5A;
      tb_dq_en  = 1'b1;
      ce_n      = 1'b0;
      oe_n      = 1'b0;
      we_n      = 1'b0;
      cyc(3);
      we_n      = 1'b1;
      oe_n      = 1'b1;
      ce_n      = 1'b1;
      tb_dq_en  = 1'b0;
      cyc(3);
      check("we_dominates_wr_count", wr_count, 7);
      check_dbg(17'h00040, 16'h5A5A, "we_dominates_dbg");
      sram_read(17'h00040, 16'h5A5A);
      check("we_dominates_rd_count", rd_count, 4);

      // reset during WR_PULSE discards the write
      sram_addr = 17'h00050;
      tb_dq     = 16'hCAFE;
      tb_dq_en  = 1'b1;
      ce_n      = 1'b0;
      we_n      = 1'b0;
      cyc(2);
      rst = 1'b1;
      #1;
      check("wr_rst_dq_z", (sram_dq === 16'hzzzz || tb_dq_en), 1);
      check("wr_rst_wr_count", wr_count, 0);
      check("wr_rst_rd_count", rd_count, 0);
      check("wr_rst_viol_wp", viol_wp, 0);
      check("wr_rst_viol_addr", viol_addr, 0);
      we_n     = 1'b1;
      ce_n     = 1'b1;
      tb_dq_en = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(2);
      check_dbg(17'h00050, 16'h1111, "wr_rst_mem_kept");
      check("wr_rst_no_late_commit", wr_count, 0);

      // reset while the responder is driving dq
      expect_read(17'h00010, 16'h1234, 1'b0, 0);
      sram_addr = 17'h00010;
      ce_n      = 1'b0;
      oe_n      = 1'b0;
      cyc(7);
      check("rd_drive_rd_count", rd_count, 1);
      rst = 1'b1;
      #1;
      check("rd_rst_dq_z", (sram_dq === 16'hzzzz), 1);
      check("rd_rst_rd_count", rd_count, 0);
      ce_n = 1'b1;
      oe_n = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(5);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
